// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states, owner
// encoding and load/store size codes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE  = 2'b01;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    // Only the exact byte code narrows an access; every other code is a doubleword.
    function automatic logic is_byte(input logic [1:0] size);
        return size == SIZE_BYTE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin picker. req[0] is instruction fetch, req[1] is
// load/store. On a tie the requester that did not own the port last time wins.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic [1:0] grant,
    output logic       valid
);

    always_comb begin
        grant = 2'b00;
        valid = |req;
        if (req == 2'b11) begin
            grant = (last_owner == OWN_IF) ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store through an IDLE/ACCESS/RESP
// sequence. Define MEM_TIMEOUT_EN to add the wait-state limit and the bus_err port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
`ifdef MEM_TIMEOUT_EN
    , output logic            bus_err
`endif
);

    if (DATA_W < 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_port_arbiter: DATA_W must be >= 8 and TIMEOUT_CYCLES >= 1");
    end

    state_t state, state_nx;
    owner_t owner, last_owner, pick;
    logic [1:0] arb_grant;
    logic arb_valid;
    logic start;
    logic timeout_hit;
    logic [DATA_W-1:0] rd_fmt;

    rr_arb2 u_arb (
        .req        ({ls_req, if_req}),
        .last_owner (last_owner),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign pick  = arb_grant[1] ? OWN_LS : OWN_IF;
    assign start = (state == IDLE) && arb_valid;
    assign rd_fmt = (mem_size == SIZE_BYTE) ? DATA_W'(mem_rdata[7:0]) : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (arb_valid) state_nx = ACCESS;
            ACCESS:  if (mem_ready || timeout_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_cs  = (state == ACCESS);
    assign if_gnt  = mem_cs && (owner == OWN_IF);
    assign ls_gnt  = mem_cs && (owner == OWN_LS);
    assign if_done = (state == RESP) && (owner == OWN_IF);
    assign ls_done = (state == RESP) && (owner == OWN_LS);
    assign busy    = (state != IDLE);

    // Request fields are latched once at arbitration so memory sees stable values
    // for every wait state regardless of what the requesters do meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_IF;
            last_owner <= OWN_LS;
            mem_we     <= 1'b0;
            mem_size   <= 2'b00;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
        end else begin
            if (start) begin
                owner      <= pick;
                last_owner <= pick;
                if (pick == OWN_IF) begin
                    mem_we    <= 1'b0;
                    mem_size  <= SIZE_DWORD;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                end else begin
                    mem_we    <= ls_we;
                    mem_size  <= ls_size;
                    mem_addr  <= ls_addr;
                    mem_wdata <= is_byte(ls_size) ? DATA_W'(ls_wdata[7:0]) : ls_wdata;
                end
            end
            if (state == ACCESS) begin
                if (mem_ready) begin
                    if (owner == OWN_IF) if_rdata <= rd_fmt;
                    else                 ls_rdata <= rd_fmt;
                end else if (timeout_hit) begin
                    if (owner == OWN_IF) if_rdata <= '0;
                    else                 ls_rdata <= '0;
                end
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;
    logic to_err;

    // The limit fires on the cycle that would make the count equal TIMEOUT_CYCLES.
    assign timeout_hit = (state == ACCESS) && !mem_ready &&
                         (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err     = (state == RESP) && to_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else if (start) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else if ((state == ACCESS) && !mem_ready) begin
            to_cnt <= to_cnt + 1'b1;
            if (timeout_hit) to_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter: directed scenarios plus
// random fetch/load-store traffic compared against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, ls_req, ls_we, mem_ready;
    logic [AW-1:0] if_addr, ls_addr, mem_addr;
    logic [DW-1:0] ls_wdata, mem_rdata, if_rdata, ls_rdata, mem_wdata;
    logic [1:0]    ls_size, mem_size;
    logic          if_gnt, if_done, ls_gnt, ls_done, mem_cs, mem_we, busy;
    logic          bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_size   (ls_size),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
`ifdef MEM_TIMEOUT_EN
        , .bus_err (bus_err)
`endif
    );

`ifndef MEM_TIMEOUT_EN
    assign bus_err = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    bit            ready_force = 1'b1;
    bit            ready_val   = 1'b1;
    bit            rdata_force = 1'b1;
    logic [DW-1:0] rdata_val   = '0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
            mem_rdata = rdata_force ? rdata_val : {$urandom, $urandom};
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int            m_st;        // 0 = port free, 1 = access pending, 2 = response due
    bit            m_last, m_own, m_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, m_if_rd, m_ls_rd, e_rd;
    logic          e_we;
    logic [1:0]    e_size;
    int            cyc, t_start, wcnt;
    int            n_if_done = 0, n_ls_done = 0;
    bit            done_own_q[$];

    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_st = 0; m_last = 1'b1; m_err = 1'b0;
                m_if_rd = '0; m_ls_rd = '0;
                exp_q.delete();
            end else begin
                if (if_done) n_if_done++;
                if (ls_done) n_ls_done++;
                if (if_done || ls_done) done_own_q.push_back(ls_done);
                case (m_st)
                    0: begin
                        check("idle_ctl", {if_gnt, ls_gnt, if_done, ls_done, mem_cs, busy, bus_err}, 0);
                        if (if_req || ls_req) begin
                            m_own   = (if_req && ls_req) ? ~m_last : ls_req;
                            m_last  = m_own;
                            e_addr  = m_own ? ls_addr : if_addr;
                            e_we    = m_own ? ls_we : 1'b0;
                            e_size  = m_own ? ls_size : 2'b11;
                            e_wdata = !m_own ? 64'h0 :
                                      (ls_size == 2'b01) ? {56'h0, ls_wdata[7:0]} : ls_wdata;
                            t_start = cyc;
                            wcnt    = 0;
                            m_st    = 1;
                        end
                    end
                    1: begin
                        check("acc_ctl", {if_gnt, ls_gnt, if_done, ls_done, mem_cs, busy, bus_err},
                              {~m_own, m_own, 2'b00, 1'b1, 1'b1, 1'b0});
                        check("mem_addr", mem_addr, e_addr);
                        check("mem_we_size", {mem_we, mem_size}, {e_we, e_size});
                        check("mem_wdata", mem_wdata, e_wdata);
                        if (mem_ready) begin
                            exp_q.push_back((e_size == 2'b01) ? {56'h0, mem_rdata[7:0]} : mem_rdata);
                            m_err = 1'b0;
                            m_st  = 2;
                        end else begin
                            wcnt++;
`ifdef MEM_TIMEOUT_EN
                            if (wcnt == TO) begin
                                exp_q.push_back(64'h0);
                                m_err = 1'b1;
                                m_st  = 2;
                            end
`endif
                        end
                    end
                    default: begin
                        check("resp_ctl", {if_gnt, ls_gnt, if_done, ls_done, mem_cs, busy, bus_err},
                              {2'b00, ~m_own, m_own, 1'b0, 1'b1, m_err});
                        check("exp_q_size", exp_q.size(), 1);
                        e_rd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                        if (m_own) m_ls_rd = e_rd;
                        else       m_if_rd = e_rd;
                        check("if_rdata", if_rdata, m_if_rd);
                        check("ls_rdata", ls_rdata, m_ls_rd);
                        check("latency", cyc - t_start, m_err ? 1 + wcnt : 2 + wcnt);
                        m_st = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- driver tasks ----------------
    int if_issued = 0, ls_issued = 0;

    task automatic wait_done(input bit is_ls);
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(is_ls ? ls_done : if_done) && budget < 400);
        check(is_ls ? "ls_done_wait" : "if_done_wait", is_ls ? ls_done : if_done, 1);
    endtask

    task automatic if_txn(input logic [AW-1:0] addr, input bit keep);
        if_req  = 1'b1;
        if_addr = addr;
        if_issued++;
        wait_done(1'b0);
        @(posedge clk);
        #1;
        if (!keep) if_req = 1'b0;
    endtask

    task automatic ls_txn(input logic we, input logic [1:0] size, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input bit keep);
        ls_req   = 1'b1;
        ls_we    = we;
        ls_size  = size;
        ls_addr  = addr;
        ls_wdata = wdata;
        ls_issued++;
        wait_done(1'b1);
        @(posedge clk);
        #1;
        if (!keep) ls_req = 1'b0;
    endtask

    task automatic wait_gnt(input bit is_ls);
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(is_ls ? ls_gnt : if_gnt) && budget < 50);
        check("gnt_wait", is_ls ? ls_gnt : if_gnt, 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_addr = '0; ls_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {if_gnt, ls_gnt, if_done, ls_done, mem_cs, mem_we, busy, bus_err}, 0);
        check("rst_mem", {mem_size, mem_addr, mem_wdata}, 0);
        check("rst_rdata", if_rdata | ls_rdata, 0);
        rst_n = 1'b1;

        // fetch with zero wait states
        rdata_val = 64'h1234_5678_9abc_def0;
        if_txn(64'h100, 1'b0);
        check("if_rdata_dir", if_rdata, 64'h1234_5678_9abc_def0);

        // byte store: only the low byte reaches memory
        ls_txn(1'b1, 2'b01, 64'h208, 64'hdead_beef_cafe_f00d, 1'b0);
        check("byte_wdata", mem_wdata, 64'h0000_0000_0000_000d);

        // byte load zero-extends
        rdata_val = 64'hffff_ffff_ffff_ff80;
        ls_txn(1'b0, 2'b01, 64'h300, 64'h0, 1'b0);
        check("byte_rdata", ls_rdata, 64'h0000_0000_0000_0080);

        // both held continuously: strict alternation starting with IF
        rdata_val = 64'h0bad_f00d_0000_0001;
        done_own_q.delete();
        fork
            for (int i = 0; i < 4; i++) if_txn(64'h400 + 64'(i * 8), i != 3);
            for (int i = 0; i < 4; i++) ls_txn(1'b0, 2'b11, 64'h800 + 64'(i * 8), 64'h0, i != 3);
        join
        check("alt_count", done_own_q.size(), 8);
        for (int i = 0; i < 8 && i < done_own_q.size(); i++)
            check("alt_order", done_own_q[i], i % 2);

        // five wait states
        ready_val = 1'b0;
        fork
            if_txn(64'h500, 1'b0);
            begin
                wait_gnt(1'b0);
                repeat (4) @(negedge clk);
                ready_val = 1'b1;
            end
        join

        // reset in the middle of an access
        ready_val = 1'b0;
        if_req  = 1'b1;
        if_addr = 64'h600;
        wait_gnt(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ctl", {if_gnt, ls_gnt, if_done, ls_done, mem_cs, mem_we, busy, bus_err}, 0);
        check("midrst_mem", {mem_size, mem_addr, mem_wdata}, 0);
        check("midrst_rdata", if_rdata | ls_rdata, 0);
        if_req = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_val = 1'b1;
        repeat (3) @(negedge clk);

`ifdef MEM_TIMEOUT_EN
        // stuck memory: bus error with zeroed data after TO wait states
        ready_val = 1'b0;
        ls_txn(1'b0, 2'b11, 64'h700, 64'h0, 1'b0);
        check("to_rdata", ls_rdata, 64'h0);
        ready_val = 1'b1;
`endif

        // random traffic
        ready_force = 1'b0;
        rdata_force = 1'b0;
        if_issued = 0; ls_issued = 0; n_if_done = 0; n_ls_done = 0;
        fork
            for (int i = 0; i < 40; i++) begin
                int gap = $urandom_range(0, 2);
                if (gap != 0) begin
                    if_req = 1'b0;
                    repeat (gap) @(posedge clk);
                    #1;
                end
                if_txn({$urandom, $urandom}, 1'b1);
            end
            for (int i = 0; i < 40; i++) begin
                int gap = $urandom_range(0, 2);
                if (gap != 0) begin
                    ls_req = 1'b0;
                    repeat (gap) @(posedge clk);
                    #1;
                end
                ls_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
            end
        join
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (4) @(negedge clk);
        check("if_done_count", n_if_done, if_issued);
        check("ls_done_count", n_ls_done, ls_issued);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
